// File: rtl/loop_jump_ctrl_if.sv
// Bundle of the start/config, iteration, body-return and completion signals
// of the hardware loop sequencer. The slave side is the sequencer itself; the
// master side is whatever drives the start request and the body datapath.
interface loop_jump_ctrl_if #(
    parameter int IDX_W = 32,
    parameter int CNT_W = 16
) ();
    logic             start_valid;
    logic             start_ready;
    logic [IDX_W-1:0] cfg_init;
    logic [IDX_W-1:0] cfg_limit;
    logic [IDX_W-1:0] cfg_step;

    logic             iter_valid;
    logic             iter_ready;
    logic [IDX_W-1:0] iter_idx;

    logic             body_done;
    logic [1:0]       body_cmd;
    logic             body_wr;
    logic [IDX_W-1:0] body_wdata;

    logic             done_valid;
    logic [1:0]       done_reason;
    logic [IDX_W-1:0] done_idx;
    logic [CNT_W-1:0] done_count;
    logic             busy;

    modport master (
        output start_valid, cfg_init, cfg_limit, cfg_step,
        output iter_ready,
        output body_done, body_cmd, body_wr, body_wdata,
        input  start_ready, iter_valid, iter_idx,
        input  done_valid, done_reason, done_idx, done_count, busy
    );

    modport slave (
        input  start_valid, cfg_init, cfg_limit, cfg_step,
        input  iter_ready,
        input  body_done, body_cmd, body_wr, body_wdata,
        output start_ready, iter_valid, iter_idx,
        output done_valid, done_reason, done_idx, done_count, busy
    );
endinterface

// File: rtl/loop_jump_ctrl.sv
// Hardware loop sequencer: walks idx from init while idx < limit in steps of
// step, offering one index at a time to a body unit and reacting to its
// continue/break/return command. The body may overwrite the loop variable.
// Optional watchdog: define LOOP_JUMP_CTRL_WATCHDOG_EN to stop the loop with
// reason 11 once MAX_ITER iterations have been accepted.
module loop_jump_ctrl #(
    parameter int IDX_W    = 32,
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 1024
) (
    input  logic            clk,
    input  logic            rst,
    loop_jump_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_BODY,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [1:0] R_NATURAL  = 2'b00;
    localparam logic [1:0] R_BREAK    = 2'b01;
    localparam logic [1:0] R_RETURN   = 2'b10;
    localparam logic [1:0] R_WATCHDOG = 2'b11;

`ifdef LOOP_JUMP_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] limit_reg, step_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       reason_next;
    logic [IDX_W-1:0] done_idx_reg;
    logic [CNT_W-1:0] done_count_reg;
    logic [1:0]       done_reason_reg;

    logic             start_fire;
    logic             iter_fire;
    logic [IDX_W:0]   step_sum;
    logic             wd_hit;
    logic             enter_done;

    assign start_fire = (state_reg == S_IDLE) && bus.start_valid;
    assign iter_fire  = (state_reg == S_ISSUE) && bus.iter_ready;
    // Extra top bit is the carry that signals the index wrapped past 2^IDX_W.
    assign step_sum   = {1'b0, idx_reg} + {1'b0, step_reg};
    // Constant-false when the watchdog is compiled out, so reason 11 can never occur.
    assign wd_hit     = WD_EN && (cnt_reg == WD_LIMIT);
    assign enter_done = (state_next == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; also picks the exit reason whenever DONE is entered.
    always_comb begin
        state_next  = state_reg;
        reason_next = R_NATURAL;
        case (state_reg)
            S_IDLE: begin
                if (start_fire) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (idx_reg < limit_reg) begin
                    state_next = S_ISSUE;
                end else begin
                    state_next  = S_DONE;
                    reason_next = R_NATURAL;
                end
            end
            S_ISSUE: begin
                if (bus.iter_ready) state_next = S_WAIT_BODY;
            end
            S_WAIT_BODY: begin
                if (bus.body_done) begin
                    case (bus.body_cmd)
                        2'b00: state_next = S_STEP;
                        2'b10: begin
                            state_next  = S_DONE;
                            reason_next = R_RETURN;
                        end
                        default: begin
                            state_next  = S_DONE;
                            reason_next = R_BREAK;
                        end
                    endcase
                end
            end
            S_STEP: begin
                if (wd_hit) begin
                    state_next  = S_DONE;
                    reason_next = R_WATCHDOG;
                end else if (step_sum[IDX_W]) begin
                    state_next  = S_DONE;
                    reason_next = R_NATURAL;
                end else begin
                    state_next = S_CHECK;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        bus.start_ready = 1'b0;
        bus.iter_valid  = 1'b0;
        bus.done_valid  = 1'b0;
        bus.busy        = 1'b1;
        case (state_reg)
            S_IDLE: begin
                bus.start_ready = 1'b1;
                bus.busy        = 1'b0;
            end
            S_ISSUE: bus.iter_valid = 1'b1;
            S_DONE:  bus.done_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: loop variable and iteration counter.
    always_comb begin
        idx_next = idx_reg;
        cnt_next = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_fire) begin
                    idx_next = bus.cfg_init;
                    cnt_next = '0;
                end
            end
            S_ISSUE: begin
                if (iter_fire && (cnt_reg != CNT_MAX)) cnt_next = cnt_reg + CNT_W'(1);
            end
            S_WAIT_BODY: begin
                // A write in the same cycle as body_done lands before the command acts.
                if (bus.body_wr) idx_next = bus.body_wdata;
            end
            S_STEP: begin
                // On a watchdog stop the pre-step index is reported, so idx is kept.
                if (!wd_hit) idx_next = step_sum[IDX_W-1:0];
            end
            default: ;
        endcase
    end

    // Datapath registers; completion results are captured on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg         <= '0;
            limit_reg       <= '0;
            step_reg        <= '0;
            cnt_reg         <= '0;
            done_idx_reg    <= '0;
            done_count_reg  <= '0;
            done_reason_reg <= 2'b00;
        end else begin
            idx_reg <= idx_next;
            cnt_reg <= cnt_next;
            if (start_fire) begin
                limit_reg <= bus.cfg_limit;
                step_reg  <= bus.cfg_step;
            end
            if (enter_done) begin
                done_idx_reg    <= idx_next;
                done_count_reg  <= cnt_next;
                done_reason_reg <= reason_next;
            end
        end
    end

    assign bus.iter_idx    = idx_reg;
    assign bus.done_idx    = done_idx_reg;
    assign bus.done_count  = done_count_reg;
    assign bus.done_reason = done_reason_reg;

endmodule

// File: tb/tb_loop_jump_ctrl.sv
// Bench for loop_jump_ctrl: directed and randomized loops checked against a
// plain for-loop reference model of the sequencer's behaviour.
module tb_loop_jump_ctrl;

    localparam int IDX_W    = 32;
    localparam int CNT_W    = 16;
    localparam int MAX_ITER = 3;
    localparam int PLAN_N   = 32;
    localparam int TMO      = 60;
`ifdef LOOP_JUMP_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    loop_jump_ctrl_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    loop_jump_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Per-iteration body behaviour, indexed by iteration number.
    logic [1:0]       plan_cmd   [PLAN_N];
    logic             plan_wr    [PLAN_N];
    logic             plan_early [PLAN_N];
    logic [IDX_W-1:0] plan_wdata [PLAN_N];
    int               plan_rdly  [PLAN_N];

    logic [IDX_W-1:0] exp_iters[$];
    logic [1:0]       exp_reason;
    logic [IDX_W-1:0] exp_idx;
    int               exp_count;

    logic [1:0]       got_reason;
    logic [IDX_W-1:0] got_idx;
    logic [CNT_W-1:0] got_count;

    task automatic plan_default();
        for (int i = 0; i < PLAN_N; i++) begin
            plan_cmd[i]   = 2'b00;
            plan_wr[i]    = 1'b0;
            plan_early[i] = 1'b0;
            plan_wdata[i] = '0;
            plan_rdly[i]  = 0;
        end
        plan_cmd[PLAN_N-1] = 2'b01;
    endtask

    // Reference: for (idx = init; idx < limit; idx += step) with body effects.
    task automatic model_run(input logic [IDX_W-1:0] init, input logic [IDX_W-1:0] limit,
                             input logic [IDX_W-1:0] step);
        longint unsigned idx;
        longint unsigned sum;
        longint unsigned modulus;
        int cnt;
        modulus = 64'd1 << IDX_W;
        exp_iters.delete();
        idx = init;
        cnt = 0;
        forever begin
            if (idx >= longint'(limit)) begin
                exp_reason = 2'b00;
                break;
            end
            exp_iters.push_back(idx[IDX_W-1:0]);
            cnt++;
            if (plan_wr[cnt-1]) idx = plan_wdata[cnt-1];
            if (plan_cmd[cnt-1] == 2'b10) begin
                exp_reason = 2'b10;
                break;
            end
            if (plan_cmd[cnt-1] != 2'b00) begin
                exp_reason = 2'b01;
                break;
            end
            if (WD && cnt == MAX_ITER) begin
                exp_reason = 2'b11;
                break;
            end
            sum = idx + step;
            if (sum >= modulus) begin
                idx = sum - modulus;
                exp_reason = 2'b00;
                break;
            end
            idx = sum;
        end
        exp_idx   = idx[IDX_W-1:0];
        exp_count = cnt;
    endtask

    // Drives one complete loop, comparing every offered index and the result.
    task automatic run_case(input string name, input logic [IDX_W-1:0] init,
                            input logic [IDX_W-1:0] limit, input logic [IDX_W-1:0] step);
        int t;
        int k;
        bit ended;
        logic [1:0] last_cmd;
        logic [IDX_W-1:0] held;
        model_run(init, limit, step);
        checks++;
        if (bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s start_ready: got %b need 1", name, bus.start_ready);
        end
        bus.start_valid = 1'b1;
        bus.cfg_init    = init;
        bus.cfg_limit   = limit;
        bus.cfg_step    = step;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.cfg_init    = $urandom;
        bus.cfg_limit   = $urandom;
        bus.cfg_step    = $urandom;
        t = 1;
        k = 0;
        ended = 1'b0;
        last_cmd = 2'b00;
        while (!ended) begin
            while (!bus.iter_valid && !bus.done_valid && t < TMO) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= TMO) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: no iter/done after %0d cycles", name, t);
                ended = 1'b1;
            end else if (bus.iter_valid) begin
                checks++;
                if (t != ((k == 0) ? 2 : 3)) begin
                    errors++;
                    $display("FAIL %s iter_latency k=%0d: got %0d need %0d", name, k, t, (k == 0) ? 2 : 3);
                end
                checks++;
                if (k >= exp_iters.size()) begin
                    errors++;
                    $display("FAIL %s extra_iter k=%0d: got idx %0d, need no more iterations", name, k, bus.iter_idx);
                    ended = 1'b1;
                end else if (bus.iter_idx !== exp_iters[k]) begin
                    errors++;
                    $display("FAIL %s iter_idx k=%0d: got %0d need %0d", name, k, bus.iter_idx, exp_iters[k]);
                end
                if (!ended) begin
                    held = bus.iter_idx;
                    // Stall the handshake while waving signals that must be ignored here.
                    for (int d = 0; d < plan_rdly[k]; d++) begin
                        bus.start_valid = 1'b1;
                        bus.body_done   = 1'b1;
                        bus.body_cmd    = 2'b01;
                        bus.body_wr     = 1'b1;
                        bus.body_wdata  = $urandom;
                        @(posedge clk); #1;
                        checks++;
                        if (bus.iter_valid !== 1'b1 || bus.iter_idx !== held || bus.start_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL %s stall k=%0d: got valid %b idx %0d ready %b need 1 %0d 0",
                                     name, k, bus.iter_valid, bus.iter_idx, bus.start_ready, held);
                        end
                    end
                    bus.start_valid = 1'b0;
                    bus.body_done   = 1'b0;
                    bus.body_wr     = 1'b0;
                    bus.iter_ready  = 1'b1;
                    @(posedge clk); #1;
                    bus.iter_ready = 1'b0;
                    if (plan_wr[k] && plan_early[k]) begin
                        bus.body_wr    = 1'b1;
                        bus.body_wdata = plan_wdata[k];
                        @(posedge clk); #1;
                        bus.body_wr = 1'b0;
                    end
                    bus.body_done  = 1'b1;
                    bus.body_cmd   = plan_cmd[k];
                    bus.body_wr    = plan_wr[k] && !plan_early[k];
                    bus.body_wdata = plan_wdata[k];
                    @(posedge clk); #1;
                    bus.body_done = 1'b0;
                    bus.body_wr   = 1'b0;
                    last_cmd = plan_cmd[k];
                    k++;
                    t = 1;
                end
            end else begin
                got_reason = bus.done_reason;
                got_idx    = bus.done_idx;
                got_count  = bus.done_count;
                if (k > 0 && last_cmd != 2'b00) begin
                    checks++;
                    if (t != 1) begin
                        errors++;
                        $display("FAIL %s done_latency: got %0d need 1", name, t);
                    end
                end
                checks++;
                if (got_reason !== exp_reason || got_idx !== exp_idx || got_count !== CNT_W'(exp_count)
                    || k != exp_iters.size()) begin
                    errors++;
                    $display("FAIL %s done: got reason %0d idx %0d count %0d iters %0d need %0d %0d %0d %0d",
                             name, got_reason, got_idx, got_count, k, exp_reason, exp_idx, exp_count,
                             exp_iters.size());
                end
                @(posedge clk); #1;
                checks++;
                if (bus.done_valid !== 1'b0 || bus.busy !== 1'b0 || bus.start_ready !== 1'b1
                    || bus.done_idx !== got_idx || bus.done_count !== got_count) begin
                    errors++;
                    $display("FAIL %s after_done: got dv %b busy %b rdy %b idx %0d cnt %0d need 0 0 1 %0d %0d",
                             name, bus.done_valid, bus.busy, bus.start_ready, bus.done_idx, bus.done_count,
                             got_idx, got_count);
                end
                ended = 1'b1;
            end
        end
        $display("case %-10s init=%0d limit=%0d step=%0d iters=%0d reason=%0d idx=%0d count=%0d",
                 name, init, limit, step, k, got_reason, got_idx, got_count);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.iter_valid !== 1'b0 || bus.done_valid !== 1'b0 || bus.busy !== 1'b0 || bus.start_ready !== 1'b1
            || bus.iter_idx !== '0 || bus.done_idx !== '0 || bus.done_count !== '0 || bus.done_reason !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got iv %b dv %b busy %b rdy %b idx %0d didx %0d cnt %0d rsn %0d need 0 0 0 1 0 0 0 0",
                     bus.iter_valid, bus.done_valid, bus.busy, bus.start_ready, bus.iter_idx,
                     bus.done_idx, bus.done_count, bus.done_reason);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset checked");
    endtask

    task automatic test_natural();
        plan_default();
        plan_rdly[0] = 3;
        run_case("natural", 32'd0, 32'd5, 32'd1);
`ifndef LOOP_JUMP_CTRL_WATCHDOG_EN
        checks++;
        if (got_reason !== 2'b00 || got_idx !== 32'd5 || got_count !== 16'd5) begin
            errors++;
            $display("FAIL natural_const: got %0d %0d %0d need 0 5 5", got_reason, got_idx, got_count);
        end
`endif
    endtask

    task automatic test_break_return();
        plan_default();
        plan_cmd[3] = 2'b01;
        run_case("break", 32'd0, 32'd10, 32'd1);
        plan_cmd[3] = 2'b10;
        run_case("return", 32'd0, 32'd10, 32'd1);
        plan_default();
        plan_cmd[1] = 2'b11;
        run_case("reserved", 32'd0, 32'd10, 32'd1);
`ifndef LOOP_JUMP_CTRL_WATCHDOG_EN
        checks++;
        if (got_reason !== 2'b01 || got_idx !== 32'd1 || got_count !== 16'd2) begin
            errors++;
            $display("FAIL reserved_const: got %0d %0d %0d need 1 1 2", got_reason, got_idx, got_count);
        end
`endif
    endtask

    task automatic test_overwrite();
        plan_default();
        plan_wr[0]    = 1'b1;
        plan_wdata[0] = 32'd10;
        run_case("overwrite", 32'd0, 32'd10, 32'd1);
        checks++;
        if (got_reason !== 2'b00 || got_idx !== 32'd11 || got_count !== 16'd1) begin
            errors++;
            $display("FAIL overwrite_const: got %0d %0d %0d need 0 11 1", got_reason, got_idx, got_count);
        end
        plan_default();
        plan_wr[1]    = 1'b1;
        plan_early[1] = 1'b1;
        plan_wdata[1] = 32'd7;
        run_case("early_wr", 32'd0, 32'd9, 32'd1);
    endtask

    task automatic test_empty();
        plan_default();
        run_case("empty", 32'd5, 32'd5, 32'd1);
        checks++;
        if (got_reason !== 2'b00 || got_idx !== 32'd5 || got_count !== 16'd0) begin
            errors++;
            $display("FAIL empty_const: got %0d %0d %0d need 0 5 0", got_reason, got_idx, got_count);
        end
    endtask

    task automatic test_wrap();
        plan_default();
        run_case("wrap", 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'd4);
        checks++;
        if (got_reason !== 2'b00 || got_idx !== 32'd2 || got_count !== 16'd2) begin
            errors++;
            $display("FAIL wrap_const: got %0d %0d %0d need 0 2 2", got_reason, got_idx, got_count);
        end
    endtask

    task automatic test_step_zero();
        plan_default();
        plan_cmd[5] = 2'b01;
        run_case("step0", 32'd0, 32'd1, 32'd0);
`ifdef LOOP_JUMP_CTRL_WATCHDOG_EN
        checks++;
        if (got_reason !== 2'b11 || got_idx !== 32'd0 || got_count !== 16'd3) begin
            errors++;
            $display("FAIL watchdog_const: got %0d %0d %0d need 3 0 3", got_reason, got_idx, got_count);
        end
`else
        checks++;
        if (got_reason !== 2'b01 || got_idx !== 32'd0 || got_count !== 16'd6) begin
            errors++;
            $display("FAIL step0_const: got %0d %0d %0d need 1 0 6", got_reason, got_idx, got_count);
        end
`endif
    endtask

    task automatic test_reset_midloop();
        int t;
        bit seen;
        bus.start_valid = 1'b1;
        bus.cfg_init    = 32'd0;
        bus.cfg_limit   = 32'd10;
        bus.cfg_step    = 32'd1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        t = 0;
        while (!bus.iter_valid && t < TMO) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (!bus.iter_valid) begin
            errors++;
            $display("FAIL midreset_iter: got no iter_valid, need one");
        end
        bus.iter_ready = 1'b1;
        @(posedge clk); #1;
        bus.iter_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1 || bus.iter_valid !== 1'b0
            || bus.done_valid !== 1'b0 || bus.done_count !== '0) begin
            errors++;
            $display("FAIL midreset_state: got busy %b rdy %b iv %b dv %b cnt %0d need 0 1 0 0 0",
                     bus.busy, bus.start_ready, bus.iter_valid, bus.done_valid, bus.done_count);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done_valid || bus.iter_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_quiet: got activity after reset, need none");
        end
        $display("reset mid-loop checked");
    endtask

    task automatic test_random();
        int r;
        logic [IDX_W-1:0] init;
        logic [IDX_W-1:0] limit;
        logic [IDX_W-1:0] step;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < PLAN_N; i++) begin
                r = $urandom_range(0, 9);
                plan_cmd[i]   = (r < 7) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
                plan_wr[i]    = ($urandom_range(0, 3) == 0);
                plan_early[i] = plan_wr[i] && ($urandom_range(0, 1) == 1);
                plan_wdata[i] = $urandom_range(0, 24);
                plan_rdly[i]  = $urandom_range(0, 2);
            end
            plan_cmd[PLAN_N-1] = 2'b01;
            if ((n % 5) == 4) begin
                init  = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                limit = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : (32'hFFFF_FFF0 | $urandom_range(0, 15));
                step  = $urandom_range(1, 7);
            end else begin
                init  = $urandom_range(0, 8);
                limit = $urandom_range(0, 20);
                step  = $urandom_range(0, 4);
            end
            run_case("random", init, limit, step);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.start_valid  = 1'b0;
        bus.cfg_init     = '0;
        bus.cfg_limit    = '0;
        bus.cfg_step     = '0;
        bus.iter_ready   = 1'b0;
        bus.body_done    = 1'b0;
        bus.body_cmd     = 2'b00;
        bus.body_wr      = 1'b0;
        bus.body_wdata   = '0;
        test_reset();
        test_natural();
        test_break_return();
        test_overwrite();
        test_empty();
        test_wrap();
        test_step_zero();
        test_reset_midloop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_jump_ctrl.md
Name: loop_jump_ctrl

Overview:
Hardware loop sequencer that issues iteration indices of a counted for-loop (init; idx < limit; idx += step) to an external body unit, one iteration at a time. After each iteration the body returns a jump command: continue, break or return. The body may also overwrite the loop variable, which changes the next index. Sits between a start/config source and a body datapath and reports exit reason, final index and iteration count.

Parameters:
IDX_W, 32, width of loop index, limit and step (unsigned)
CNT_W, 16, width of the iteration counter
MAX_ITER, 1024, watchdog iteration cap (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start_valid  in  1  loop start request
start_ready  out  1  high only in IDLE
cfg_init  in  IDX_W  initial index, sampled on start handshake
cfg_limit  in  IDX_W  exclusive upper bound, sampled on start handshake
cfg_step  in  IDX_W  increment, sampled on start handshake
iter_valid  out  1  iteration offered
iter_ready  in  1  body accepts iteration
iter_idx  out  IDX_W  current index, stable while iter_valid
body_done  in  1  body finished the current iteration
body_cmd  in  2  jump command: 00 continue, 01 break, 10 return, 11 reserved (treated as break)
body_wr  in  1  overwrite the loop variable
body_wdata  in  IDX_W  new loop variable value
done_valid  out  1  one-cycle completion pulse
done_reason  out  2  00 natural exit, 01 break, 10 return, 11 watchdog
done_idx  out  IDX_W  index at exit
done_count  out  CNT_W  iterations accepted by the body
busy  out  1  high when not IDLE

Behaviour:
- Reset (synchronous): state IDLE. iter_valid, done_valid and busy are 0; start_ready is 1; iter_idx, done_idx, done_count and done_reason are 0. A reset mid-loop aborts the loop with no done pulse.
- States: IDLE, CHECK, ISSUE, WAIT_BODY, STEP, DONE.
- IDLE: on start_valid && start_ready, latch cfg_init into idx, latch limit and step, clear cnt, go to CHECK.
- CHECK: if idx < limit (unsigned), go to ISSUE. Otherwise go to DONE with reason 00.
- ISSUE: iter_valid = 1 and iter_idx = idx, held until iter_ready. On the handshake, cnt is incremented (saturates at all-ones) and the state goes to WAIT_BODY.
- WAIT_BODY: body_wr without body_done sets idx to body_wdata. body_wr together with body_done applies the write first, then the command.
  - cmd 00: go to STEP.
  - cmd 01 or 11: go to DONE with reason 01.
  - cmd 10: go to DONE with reason 10.
- body_done and body_wr are ignored in every state except WAIT_BODY.
- STEP: compute {carry, idx} <= idx + step at IDX_W+1 bits.
  - carry = 1: go to DONE with reason 00, and done_idx is the wrapped value.
  - carry = 0: go to CHECK.
- step = 0 is legal. The loop then runs until a break or return.
- DONE: done_valid = 1 for exactly one cycle, with done_idx = idx, done_count = cnt and done_reason. Next state is IDLE. done_idx, done_count and done_reason hold their values until the next DONE.
- Latency:
  - Start handshake to first iter_valid: 2 cycles.
  - body_done (continue) to next iter_valid: 3 cycles (STEP, CHECK, ISSUE).
  - body_done (break/return) to done_valid: 1 cycle.
- body_done may arrive no earlier than the cycle after the iter handshake.
- Start requests during busy are not accepted (start_ready = 0).

Optional Feature:
LOOP_JUMP_CTRL_WATCHDOG_EN
- Defined: in STEP, if cnt == MAX_ITER, go to DONE with reason 11 and done_idx = the pre-step idx. This check takes priority over carry and limit.
- Undefined: no cap, and reason 11 is never produced. MAX_ITER is unused.

Test Plan:
- init 0, limit 5, step 1, body always cmd 00 -> iter_idx 0,1,2,3,4; done reason 00, idx 5, count 5.
- init 0, limit 10, step 1, break (cmd 01) at idx 3 -> iter_idx 0..3; done reason 01, idx 3, count 4. Repeat with cmd 10 -> reason 10, idx 3.
- init 0, limit 10, body_wr wdata 10 with cmd 00 at idx 0 -> one iteration only; done reason 00, idx 11, count 1.
- init 5, limit 5 -> no iter_valid; done_valid 2 cycles after start, reason 00, idx 5, count 0. Also check that iter_ready held low for 3 cycles stretches ISSUE with iter_idx stable.
- IDX_W=8, init 250, limit 255, step 4 -> iter_idx 250, 254; done reason 00, idx 2 (wrapped), count 2.
- With LOOP_JUMP_CTRL_WATCHDOG_EN and MAX_ITER=3, step 0, limit 1 -> 3 iterations at idx 0; done reason 11, count 3. Also assert rst in WAIT_BODY -> next cycle IDLE, no done_valid, start_ready 1.
